// File: rtl/bbb_array_pkg.sv
// bbb_array_pkg: shared defaults, level type, column map and LFSR constants for the mic-array emulator
package bbb_array_pkg;
    localparam int NUM_ROWS_DEF  = 5;
    localparam int NUM_COLS_DEF  = 8;
    localparam int ACC_WIDTH_DEF = 16;
    typedef logic [ACC_WIDTH_DEF-1:0] level_t;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    function automatic int sel2col(input int s, input int n);
        return (s < n/2) ? n/2-1-s : n+n/2-1-s;
    endfunction
endpackage

// File: rtl/bbb_array_emulator_if.sv
// bbb_array_emulator_if: sampler-facing bus of the mic-array emulator (master = sampler, slave = emulator)
interface bbb_array_emulator_if import bbb_array_pkg::*; #(
    parameter int NUM_ROWS   = NUM_ROWS_DEF,
    parameter int NUM_COLS   = NUM_COLS_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int SEL_WIDTH  = $clog2(NUM_COLS),
    parameter int ADDR_WIDTH = $clog2(NUM_ROWS*NUM_COLS)
);
    logic                  en;
    logic                  lr_sel;
    logic                  pdm_clk;
    logic [SEL_WIDTH-1:0]  array_sel;
    logic                  cfg_wr;
    logic [ADDR_WIDTH-1:0] cfg_addr;
    logic [ACC_WIDTH-1:0]  cfg_wdata;
    logic [NUM_ROWS-1:0]   pdm_out_ff;
    logic [15:0]           edge_cnt_ff;
    modport master(output en, lr_sel, pdm_clk, array_sel, cfg_wr, cfg_addr, cfg_wdata,
                   input pdm_out_ff, edge_cnt_ff);
    modport slave(input en, lr_sel, pdm_clk, array_sel, cfg_wr, cfg_addr, cfg_wdata,
                  output pdm_out_ff, edge_cnt_ff);
endinterface

// File: rtl/bbb_sdm_cell.sv
// bbb_sdm_cell: one emulated mic, a first-order sigma-delta modulator with a programmable level
module bbb_sdm_cell import bbb_array_pkg::*; #(
    parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 step,
    input  logic                 cin,
    input  logic [ACC_WIDTH-1:0] level,
    output logic                 bit_ff
);
    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH:0]   w_sum;
    assign w_sum = {1'b0, r_acc} + {1'b0, level} + {{ACC_WIDTH{1'b0}}, cin};
    // accumulate on each step; disabling clears the modulator back to its start state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc  <= '0;
            bit_ff <= 1'b0;
        end else if (!en) begin
            r_acc  <= '0;
            bit_ff <= 1'b0;
        end else if (step) begin
            r_acc  <= w_sum[ACC_WIDTH-1:0];
            bit_ff <= w_sum[ACC_WIDTH];
        end
    end
endmodule

// File: rtl/bbb_array_emulator.sv
// bbb_array_emulator: BeagleBone mic-array shield model; optional dither carry-in via BBB_EMU_DITHER_EN
module bbb_array_emulator import bbb_array_pkg::*; #(
    parameter int NUM_ROWS   = NUM_ROWS_DEF,
    parameter int NUM_COLS   = NUM_COLS_DEF,
    parameter int SEL_WIDTH  = $clog2(NUM_COLS),
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int MUX_LAT    = 2,
    parameter int ADDR_WIDTH = $clog2(NUM_ROWS*NUM_COLS)
) (
    input logic                 clk,
    input logic                 reset,
    bbb_array_emulator_if.slave bus
);
    localparam int NUM_MICS = NUM_ROWS*NUM_COLS;
    logic                 r_pdm_clk_q;
    logic                 w_act_edge;
    logic                 w_step;
    logic                 w_cin;
    logic [ACC_WIDTH-1:0] r_level [NUM_MICS];
    logic [NUM_MICS-1:0]  w_bits;
    logic [NUM_ROWS-1:0]  w_mux;
    logic [NUM_ROWS-1:0]  r_pipe [MUX_LAT];
    logic [15:0]          r_edge_cnt;
    assign w_act_edge = bus.lr_sel ? (bus.pdm_clk & ~r_pdm_clk_q) : (~bus.pdm_clk & r_pdm_clk_q);
    assign w_step = w_act_edge & bus.en;
`ifdef BBB_EMU_DITHER_EN
    logic [15:0] r_lfsr;
    // dither source: advances once per active pdm_clk edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_lfsr <= LFSR_SEED;
        else if (w_act_edge) r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
    end
    assign w_cin = r_lfsr[0];
`else
    assign w_cin = 1'b0;
`endif
    // pdm_clk history for edge detection and the running count of enabled active edges
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pdm_clk_q <= 1'b0;
            r_edge_cnt  <= '0;
        end else begin
            r_pdm_clk_q <= bus.pdm_clk;
            if (w_step) r_edge_cnt <= r_edge_cnt + 16'd1;
        end
    end
    // level registers; out-of-range addresses are dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_MICS; i++) r_level[i] <= '0;
        end else if (bus.cfg_wr && int'(bus.cfg_addr) < NUM_MICS) begin
            r_level[bus.cfg_addr] <= bus.cfg_wdata;
        end
    end
    for (genvar g = 0; g < NUM_MICS; g++) begin : g_mic
        bbb_sdm_cell #(.ACC_WIDTH(ACC_WIDTH)) u_cell (
            .clk   (clk),
            .reset (reset),
            .en    (bus.en),
            .step  (w_step),
            .cin   (w_cin),
            .level (r_level[g]),
            .bit_ff(w_bits[g])
        );
    end
    // column mux: selected column's rows onto the PDM lines, unused selects read as silence
    always_comb begin
        logic [ADDR_WIDTH-1:0] idx;
        int col;
        w_mux = '0;
        idx   = '0;
        col   = sel2col(int'(bus.array_sel), NUM_COLS);
        for (int r = 0; r < NUM_ROWS; r++) begin
            idx      = ADDR_WIDTH'(col*NUM_ROWS + r);
            w_mux[r] = (int'(bus.array_sel) < NUM_COLS) ? w_bits[idx] : 1'b0;
        end
    end
    // latency pipe mimicking the shield's mux settling time
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MUX_LAT; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= w_mux;
            for (int i = 1; i < MUX_LAT; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end
    assign bus.pdm_out_ff  = r_pipe[MUX_LAT-1];
    assign bus.edge_cnt_ff = r_edge_cnt;
endmodule

// File: tb/tb_bbb_array_emulator.sv
// tb_bbb_array_emulator: table-driven and scoreboard checks of the mic-array emulator
module tb_bbb_array_emulator;
    import bbb_array_pkg::*;
    localparam int MUX_LAT = 2;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [4:0] exp_q[$];
    typedef struct {
        logic        lr;
        logic [15:0] level;
        int          n;
        logic [15:0] pat;
    } vec_t;
    vec_t vecs[6];
    always #5 clk = ~clk;
    bbb_array_emulator_if bus();
    bbb_array_emulator #(.MUX_LAT(MUX_LAT)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask
    task automatic write_level(input int addr, input logic [15:0] lvl);
        bus.cfg_wr    = 1'b1;
        bus.cfg_addr  = 6'(addr);
        bus.cfg_wdata = lvl;
        tick();
        bus.cfg_wr = 1'b0;
    endtask
    task automatic pdm_period();
        bus.pdm_clk = 1'b1;
        tick();
        bus.pdm_clk = 1'b0;
        tick();
    endtask
    task automatic pdm_edge(input logic [4:0] exp, input string name, input bit wr, input logic [15:0] wdata);
        exp_q.push_back(exp);
        bus.pdm_clk = 1'b1;
        if (wr) begin
            bus.cfg_wr    = 1'b1;
            bus.cfg_addr  = '0;
            bus.cfg_wdata = wdata;
        end
        tick();
        bus.cfg_wr  = 1'b0;
        bus.pdm_clk = 1'b0;
        repeat (MUX_LAT + 1) tick();
        check(name, 32'(bus.pdm_out_ff), 32'(exp_q.pop_front()));
    endtask
    initial begin
        logic [4:0] prev;
        logic [4:0] expv;
        vecs[0] = '{1'b1, 16'h8000, 8, 16'h00AA};
        vecs[1] = '{1'b1, 16'hFFFF, 10, 16'h03FE};
        vecs[2] = '{1'b1, 16'h0000, 10, 16'h0000};
        vecs[3] = '{1'b1, 16'h4000, 8, 16'h0088};
        vecs[4] = '{1'b1, 16'hC000, 8, 16'h00EE};
        vecs[5] = '{1'b0, 16'h8000, 8, 16'h00AA};
        bus.en = 1'b1; bus.lr_sel = 1'b1; bus.pdm_clk = 1'b0; bus.array_sel = 3'd3;
        bus.cfg_wr = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
        tick(); tick();
        check("reset pdm_out", 32'(bus.pdm_out_ff), 0);
        check("reset edge_cnt", 32'(bus.edge_cnt_ff), 0);
        reset = 1'b0;
        tick();
        // mic 0 (col 0) is reached through array_sel 3
        for (int v = 0; v < 6; v++) begin
            do_reset();
            bus.lr_sel = vecs[v].lr;
            write_level(0, vecs[v].level);
            for (int e = 0; e < vecs[v].n; e++)
                pdm_edge({4'b0, vecs[v].pat[e]}, $sformatf("vec%0d edge%0d", v, e), 1'b0, 16'h0);
            check($sformatf("vec%0d edge_cnt", v), 32'(bus.edge_cnt_ff), 32'(vecs[v].n));
        end
        bus.lr_sel = 1'b1;
        // column map: col3,row2 -> sel 0 (bit 2); col5,row0 -> sel 6 (bit 0)
        do_reset();
        write_level(17, 16'hFFFF);
        write_level(25, 16'hFFFF);
        bus.array_sel = 3'd7;
        pdm_edge(5'b0, "map warm0", 1'b0, 16'h0);
        pdm_edge(5'b0, "map warm1", 1'b0, 16'h0);
        prev = 5'b0;
        for (int s = 0; s < 8; s++) begin
            bus.array_sel = 3'(s);
            expv = (s == 0) ? 5'b00100 : (s == 6) ? 5'b00001 : 5'b0;
            repeat (MUX_LAT - 1) tick();
            check($sformatf("map sel%0d early", s), 32'(bus.pdm_out_ff), 32'(prev));
            tick();
            check($sformatf("map sel%0d", s), 32'(bus.pdm_out_ff), 32'(expv));
            prev = expv;
        end
        // write coincident with an active edge: old level 0x8000 used, then 0xFFFF
        do_reset();
        bus.array_sel = 3'd3;
        write_level(0, 16'h8000);
        pdm_edge(5'd0, "coll e0", 1'b0, 16'h0);
        pdm_edge(5'd1, "coll e1", 1'b1, 16'hFFFF);
        pdm_edge(5'd0, "coll e2", 1'b0, 16'h0);
        pdm_edge(5'd1, "coll e3", 1'b0, 16'h0);
        write_level(40, 16'h0000);
        pdm_edge(5'd1, "coll e4 after addr40", 1'b0, 16'h0);
        pdm_edge(5'd1, "coll e5", 1'b0, 16'h0);
        check("coll edge_cnt", 32'(bus.edge_cnt_ff), 6);
        // enable gating
        do_reset();
        write_level(0, 16'h8000);
        pdm_edge(5'd0, "en e0", 1'b0, 16'h0);
        pdm_edge(5'd1, "en e1", 1'b0, 16'h0);
        pdm_edge(5'd0, "en e2", 1'b0, 16'h0);
        bus.en = 1'b0;
        repeat (3) pdm_period();
        repeat (MUX_LAT) tick();
        check("en off pdm_out", 32'(bus.pdm_out_ff), 0);
        check("en off edge_cnt", 32'(bus.edge_cnt_ff), 3);
        bus.lr_sel = 1'b0;
        tick();
        bus.lr_sel = 1'b1;
        tick();
        check("lr_sel toggle edge_cnt", 32'(bus.edge_cnt_ff), 3);
        bus.en = 1'b1;
        pdm_edge(5'd0, "en re0", 1'b0, 16'h0);
        pdm_edge(5'd1, "en re1", 1'b0, 16'h0);
        pdm_edge(5'd0, "en re2", 1'b0, 16'h0);
        pdm_edge(5'd1, "en re3", 1'b0, 16'h0);
        check("en re edge_cnt", 32'(bus.edge_cnt_ff), 7);
        // asynchronous reset while a 1 is on the line
        #2;
        reset = 1'b1;
        #1;
        check("async pdm_out", 32'(bus.pdm_out_ff), 0);
        check("async edge_cnt", 32'(bus.edge_cnt_ff), 0);
        tick();
        reset = 1'b0;
        tick();
        write_level(0, 16'h8000);
        for (int e = 0; e < 8; e++)
            pdm_edge({4'b0, vecs[0].pat[e]}, $sformatf("restart edge%0d", e), 1'b0, 16'h0);
        check("restart edge_cnt", 32'(bus.edge_cnt_ff), 8);
`ifdef BBB_EMU_DITHER_EN
        begin
            int ones;
            int miss;
            logic [15:0] m_lfsr;
            logic [15:0] m_acc;
            logic [16:0] m_sum;
            do_reset();
            write_level(0, 16'h8000);
            ones = 0; miss = 0; m_lfsr = LFSR_SEED; m_acc = '0;
            // pdm_clk and lr_sel move together so every clk is one active edge
            for (int i = 0; i < 65538; i++) begin
                if (i < 65536) begin
                    bus.pdm_clk = ~bus.pdm_clk;
                    bus.lr_sel  = bus.pdm_clk;
                end
                tick();
                if (i >= 2) begin
                    m_sum  = {1'b0, m_acc} + 17'h08000 + {16'b0, m_lfsr[0]};
                    m_acc  = m_sum[15:0];
                    m_lfsr = {m_lfsr[14:0], ^(m_lfsr & LFSR_TAPS)};
                    ones  += int'(bus.pdm_out_ff[0]);
                    if (bus.pdm_out_ff[0] !== m_sum[16]) miss++;
                end
            end
            check("dither ones in 32768+-1", 32'(ones >= 32767 && ones <= 32769), 1);
            check("dither stream vs model", 32'(miss), 0);
            check("dither edge_cnt wrap", 32'(bus.edge_cnt_ff), 0);
            bus.lr_sel = 1'b1;
        end
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
